// File: rtl/alu_issue_arb.sv
// alu_issue_arb: arbitrates two requesters onto one shared combinational ALU
// and buffers the ALU results in a small FIFO that feeds a writeback stream.
// Optional feature macro: ALU_ISSUE_ARB_RR_EN enables round-robin tie
// breaking. When it is undefined, requester 0 always wins a tie.
`timescale 1ns/1ps
module alu_issue_arb #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req0_valid,
  input  logic        i_req1_valid,
  output logic        o_req0_ready,
  output logic        o_req1_ready,
  input  logic [4:0]  i_req0_rd_idx,
  input  logic        i_req0_rd_wen,
  input  logic [31:0] i_req0_rs1,
  input  logic [31:0] i_req0_rs2,
  input  logic        i_req0_add_op,
  input  logic [4:0]  i_req1_rd_idx,
  input  logic        i_req1_rd_wen,
  input  logic [31:0] i_req1_rs1,
  input  logic [31:0] i_req1_rs2,
  input  logic        i_req1_add_op,
  output logic [4:0]  o_alu_rd_idx,
  output logic        o_alu_rd_wen,
  output logic [31:0] o_alu_rs1,
  output logic [31:0] o_alu_rs2,
  output logic        o_alu_add_op,
  input  logic [31:0] i_alu_wdat,
  input  logic [4:0]  i_alu_rd_idx,
  input  logic        i_alu_rd_wen,
  output logic        o_wb_valid,
  input  logic        i_wb_ready,
  output logic [31:0] o_wb_wdat,
  output logic [4:0]  o_wb_rd_idx,
  output logic        o_wb_rd_wen,
  output logic        o_wb_src
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 39;  // {src, wen, rd_idx[4:0], wdat[31:0]}

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic [EW-1:0] mem [FIFO_DEPTH];

  logic pop;
  logic push;
  logic can_accept;
  logic grant;
  logic sel;
  logic tie_sel;

  // A pop only happens when a head entry exists and the consumer takes it.
  assign pop        = (count != CW'(0)) && i_wb_ready;
  // A full queue still accepts when its head leaves in the same cycle.
  assign can_accept = (count < CW'(FIFO_DEPTH)) || pop;
  assign push       = grant;

`ifdef ALU_ISSUE_ARB_RR_EN
  logic lg;

  // Last-grant register; reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      lg <= 1'b1;
    end else if (grant) begin
      lg <= sel;
    end else begin
      lg <= lg;
    end
  end

  assign tie_sel = ~lg;
`else
  assign tie_sel = 1'b0;
`endif

  // Pick the requester to grant this cycle; nothing is granted in reset or
  // when the queue has no room.
  always_comb begin
    grant = 1'b0;
    sel   = 1'b0;
    if (rst || !can_accept) begin
      grant = 1'b0;
      sel   = 1'b0;
    end else if (i_req0_valid && i_req1_valid) begin
      grant = 1'b1;
      sel   = tie_sel;
    end else if (i_req0_valid) begin
      grant = 1'b1;
      sel   = 1'b0;
    end else if (i_req1_valid) begin
      grant = 1'b1;
      sel   = 1'b1;
    end else begin
      grant = 1'b0;
      sel   = 1'b0;
    end
  end

  assign o_req0_ready = grant & ~sel;
  assign o_req1_ready = grant & sel;

  // Route the granted requester's operands to the ALU; idle drives zeros.
  always_comb begin
    o_alu_rd_idx = 5'd0;
    o_alu_rd_wen = 1'b0;
    o_alu_rs1    = 32'd0;
    o_alu_rs2    = 32'd0;
    o_alu_add_op = 1'b0;
    if (grant && sel) begin
      o_alu_rd_idx = i_req1_rd_idx;
      o_alu_rd_wen = i_req1_rd_wen;
      o_alu_rs1    = i_req1_rs1;
      o_alu_rs2    = i_req1_rs2;
      o_alu_add_op = i_req1_add_op;
    end else if (grant) begin
      o_alu_rd_idx = i_req0_rd_idx;
      o_alu_rd_wen = i_req0_rd_wen;
      o_alu_rs1    = i_req0_rs1;
      o_alu_rs2    = i_req0_rs2;
      o_alu_add_op = i_req0_add_op;
    end else begin
      o_alu_rd_idx = 5'd0;
      o_alu_rd_wen = 1'b0;
      o_alu_rs1    = 32'd0;
      o_alu_rs2    = 32'd0;
      o_alu_add_op = 1'b0;
    end
  end

  // Result storage: capture the ALU result of the granted op at the tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wptr] <= {sel, i_alu_rd_wen, i_alu_rd_idx, i_alu_wdat};
    end else begin
      mem[wptr] <= mem[wptr];
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= push ? wptr + PW'(1) : wptr;
      rptr <= pop  ? rptr + PW'(1) : rptr;
    end
  end

  // Occupancy counter; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign o_wb_valid  = (count != CW'(0));
  assign o_wb_src    = mem[rptr][38];
  assign o_wb_rd_wen = mem[rptr][37];
  assign o_wb_rd_idx = mem[rptr][36:32];
  assign o_wb_wdat   = mem[rptr][31:0];

endmodule

// File: tb/tb_alu_issue_arb.sv
// Directed testbench for alu_issue_arb with a behavioural model of the
// external ALU (add when add_op=1, otherwise zero result).
`timescale 1ns/1ps
module tb_alu_issue_arb;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_rd_idx, req1_rd_idx;
  logic        req0_rd_wen, req1_rd_wen;
  logic [31:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
  logic        req0_add_op, req1_add_op;
  logic [4:0]  alu_rd_idx;
  logic        alu_rd_wen;
  logic [31:0] alu_rs1, alu_rs2;
  logic        alu_add_op;
  logic [31:0] alu_wdat;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_wdat;
  logic [4:0]  wb_rd_idx;
  logic        wb_rd_wen, wb_src;

  int errors = 0;
  int checks = 0;

`ifdef ALU_ISSUE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  alu_issue_arb #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .i_req0_valid(req0_valid), .i_req1_valid(req1_valid),
    .o_req0_ready(req0_ready), .o_req1_ready(req1_ready),
    .i_req0_rd_idx(req0_rd_idx), .i_req0_rd_wen(req0_rd_wen),
    .i_req0_rs1(req0_rs1), .i_req0_rs2(req0_rs2), .i_req0_add_op(req0_add_op),
    .i_req1_rd_idx(req1_rd_idx), .i_req1_rd_wen(req1_rd_wen),
    .i_req1_rs1(req1_rs1), .i_req1_rs2(req1_rs2), .i_req1_add_op(req1_add_op),
    .o_alu_rd_idx(alu_rd_idx), .o_alu_rd_wen(alu_rd_wen),
    .o_alu_rs1(alu_rs1), .o_alu_rs2(alu_rs2), .o_alu_add_op(alu_add_op),
    .i_alu_wdat(alu_wdat), .i_alu_rd_idx(alu_rd_idx), .i_alu_rd_wen(alu_rd_wen),
    .o_wb_valid(wb_valid), .i_wb_ready(wb_ready), .o_wb_wdat(wb_wdat),
    .o_wb_rd_idx(wb_rd_idx), .o_wb_rd_wen(wb_rd_wen), .o_wb_src(wb_src)
  );

  // Shared combinational ALU model.
  assign alu_wdat = alu_add_op ? (alu_rs1 + alu_rs2) : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic add, input logic [4:0] rd, input logic wen);
    req0_valid = v; req0_rs1 = a; req0_rs2 = b;
    req0_add_op = add; req0_rd_idx = rd; req0_rd_wen = wen;
  endtask

  task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic add, input logic [4:0] rd, input logic wen);
    req1_valid = v; req1_rs1 = a; req1_rs2 = b;
    req1_add_op = add; req1_rd_idx = rd; req1_rd_wen = wen;
  endtask

  initial begin
    logic exp_sel;
    logic [31:0] prev_wdat;
    prev_wdat = 32'h0;
    rst = 1'b1;
    wb_ready = 1'b0;
    set0(1'b1, 32'd1, 32'd1, 1'b1, 5'd1, 1'b1);
    set1(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    tick();
    // Reset state: no readiness even with a valid request.
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    tick();
    rst = 1'b0;
    set0(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    #1;
    chk("post_rst_wb_valid", wb_valid, 1'b0);

    // Single add from requester 0, result one cycle later.
    set0(1'b1, 32'd5, 32'd7, 1'b1, 5'd3, 1'b1);
    wb_ready = 1'b1;
    #1;
    chk("add_ready0", req0_ready, 1'b1);
    chk("add_ready1", req1_ready, 1'b0);
    chk("add_alu_rs1", alu_rs1, 32'd5);
    chk("add_alu_op", alu_add_op, 1'b1);
    tick();
    set0(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    #1;
    chk("add_wb_valid", wb_valid, 1'b1);
    chk("add_wb_wdat", wb_wdat, 32'd12);
    chk("add_wb_rd", wb_rd_idx, 5'd3);
    chk("add_wb_wen", wb_rd_wen, 1'b1);
    chk("add_wb_src", wb_src, 1'b0);
    tick();
    chk("add_drained", wb_valid, 1'b0);

    // Invalid request fields are ignored and the ALU sees zeros.
    set0(1'b0, 32'hDEAD, 32'd1, 1'b1, 5'd7, 1'b1);
    #1;
    chk("idle_alu_rs1", alu_rs1, 32'd0);
    chk("idle_alu_op", alu_add_op, 1'b0);
    chk("idle_alu_wen", alu_rd_wen, 1'b0);
    chk("idle_ready0", req0_ready, 1'b0);
    set0(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);

    // 32-bit wrap: non-add op and add op both produce zero.
    set1(1'b1, 32'hFFFFFFFF, 32'd1, 1'b0, 5'd9, 1'b1);
    #1;
    chk("wrap_ready1", req1_ready, 1'b1);
    tick();
    set1(1'b1, 32'hFFFFFFFF, 32'd1, 1'b1, 5'd10, 1'b1);
    #1;
    chk("wrap0_wb_wdat", wb_wdat, 32'd0);
    chk("wrap0_wb_rd", wb_rd_idx, 5'd9);
    chk("wrap0_wb_src", wb_src, 1'b1);
    chk("wrap1_ready1", req1_ready, 1'b1);
    tick();
    set1(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    #1;
    chk("wrap1_wb_wdat", wb_wdat, 32'd0);
    chk("wrap1_wb_rd", wb_rd_idx, 5'd10);
    tick();

    // Continuous tie: alternating with round-robin, else requester 0 always.
    set0(1'b1, 32'd100, 32'd0, 1'b1, 5'd1, 1'b1);
    set1(1'b1, 32'd200, 32'd0, 1'b1, 5'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_sel = RR ? ((i % 2) == 1) : 1'b0;
      chk("tie_ready0", req0_ready, !exp_sel);
      chk("tie_ready1", req1_ready, exp_sel);
      if (i > 0) chk("tie_wb_wdat", wb_wdat, prev_wdat);
      prev_wdat = exp_sel ? 32'd200 : 32'd100;
      tick();
    end
    set0(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    set1(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    #1;
    chk("tie_last_wdat", wb_wdat, prev_wdat);
    tick();
    chk("tie_drained", wb_valid, 1'b0);

    // Backpressure: two accepts then stall, head stays stable.
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set0(1'b1, 32'(i + 1), 32'd0, 1'b1, 5'(i), 1'b1);
      #1;
      chk("bp_ready0", req0_ready, i < 2);
      if (i >= 1) chk("bp_head_stable", wb_wdat, 32'd1);
      tick();
    end
    set0(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    wb_ready = 1'b1;
    #1;
    chk("bp_drain1_valid", wb_valid, 1'b1);
    chk("bp_drain1_wdat", wb_wdat, 32'd1);
    tick();
    chk("bp_drain2_wdat", wb_wdat, 32'd2);
    chk("bp_drain2_rd", wb_rd_idx, 5'd1);
    tick();
    chk("bp_drained", wb_valid, 1'b0);

    // Full queue with simultaneous pop and push from requester 1.
    wb_ready = 1'b0;
    set0(1'b1, 32'd21, 32'd0, 1'b1, 5'd4, 1'b1);
    tick();
    set0(1'b1, 32'd22, 32'd0, 1'b1, 5'd5, 1'b1);
    #1;
    chk("fill_ready0", req0_ready, 1'b1);
    tick();
    set0(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    set1(1'b1, 32'd33, 32'd0, 1'b1, 5'd6, 1'b1);
    wb_ready = 1'b1;
    #1;
    chk("pushpop_ready1", req1_ready, 1'b1);
    chk("pushpop_head", wb_wdat, 32'd21);
    tick();
    wb_ready = 1'b0;
    #1;
    chk("full_no_pop_ready1", req1_ready, 1'b0);
    chk("pushpop_next_head", wb_wdat, 32'd22);
    chk("pushpop_next_src", wb_src, 1'b0);
    set1(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    wb_ready = 1'b1;
    tick();
    chk("pushpop_tail_wdat", wb_wdat, 32'd33);
    chk("pushpop_tail_src", wb_src, 1'b1);
    chk("pushpop_tail_rd", wb_rd_idx, 5'd6);
    tick();
    chk("pushpop_drained", wb_valid, 1'b0);

    // Reset with two entries queued discards them and restores tie order.
    wb_ready = 1'b0;
    set0(1'b1, 32'd41, 32'd0, 1'b1, 5'd1, 1'b1);
    tick();
    set0(1'b1, 32'd42, 32'd0, 1'b1, 5'd2, 1'b1);
    tick();
    chk("prerst_full_valid", wb_valid, 1'b1);
    set1(1'b1, 32'd43, 32'd0, 1'b1, 5'd3, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_ready0", req0_ready, 1'b0);
    chk("midrst_ready1", req1_ready, 1'b0);
    tick();
    rst = 1'b0;
    set0(1'b1, 32'd50, 32'd0, 1'b1, 5'd7, 1'b1);
    set1(1'b1, 32'd60, 32'd0, 1'b1, 5'd8, 1'b1);
    #1;
    chk("rst_flush_valid", wb_valid, 1'b0);
    chk("rst_tie_ready0", req0_ready, 1'b1);
    chk("rst_tie_ready1", req1_ready, 1'b0);
    tick();
    set0(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    set1(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    #1;
    chk("rst_tie_wb_valid", wb_valid, 1'b1);
    chk("rst_tie_wb_wdat", wb_wdat, 32'd50);
    chk("rst_tie_wb_src", wb_src, 1'b0);
    wb_ready = 1'b1;
    tick();
    chk("final_drained", wb_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
